// File: rtl/fpnew_rounding_lanes.sv
// fpnew_rounding_lanes
// Multi-lane magnitude rounding unit with a valid/ready pipeline.
// Each lane applies the shared rounding mode to its magnitude and {R,S} bits,
// then the results travel through NumPipeRegs handshake-controlled stages.
// Optional feature: define FPNEW_ROUNDING_STATUS_EN to build the sticky
// inexact accumulator behind status_o / status_clr_i; without it status_o is 0.
module fpnew_rounding_lanes #(
  parameter int unsigned AbsWidth    = 8,
  parameter int unsigned NumLanes    = 4,
  parameter int unsigned NumPipeRegs = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  // Input handshake and operands
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [NumLanes*AbsWidth-1:0] abs_value_i,
  input  logic [NumLanes-1:0]          sign_i,
  input  logic [NumLanes-1:0]          effective_subtraction_i,
  input  logic [NumLanes-1:0]          lane_mask_i,
  input  logic [2*NumLanes-1:0]        round_sticky_bits_i,
  input  logic [2:0]                   rnd_mode_i,
  // Output handshake and results
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [NumLanes*AbsWidth-1:0] abs_rounded_o,
  output logic [NumLanes-1:0]          sign_o,
  output logic [NumLanes-1:0]          exact_zero_o,
  output logic [NumLanes-1:0]          inexact_o,
  output logic [NumLanes-1:0]          carry_o,
  output logic                         mode_err_o,
  // Sticky inexact status
  output logic [NumLanes-1:0]          status_o,
  input  logic                         status_clr_i
);

  // --------------------------------------------------------------------------
  // Types
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4,
    ROD = 3'd5
  } rnd_mode_e;

  // Everything one transaction carries from the rounding logic to the outputs.
  typedef struct packed {
    logic [NumLanes*AbsWidth-1:0] abs;
    logic [NumLanes-1:0]          sign;
    logic [NumLanes-1:0]          exact_zero;
    logic [NumLanes-1:0]          inexact;
    logic [NumLanes-1:0]          carry;
    logic                         mode_err;
  } stage_t;

  // Round-up decision for one lane given the effective mode.
  function automatic logic round_up_decision(input rnd_mode_e mode,
                                             input logic      lsb,
                                             input logic      sign,
                                             input logic      r,
                                             input logic      s);
    logic up;
    up = 1'b0;
    case (mode)
      RNE:     up = r & (s | lsb);      // above half, or exact tie to odd lsb
      RTZ:     up = 1'b0;
      RDN:     up = (r | s) & sign;     // toward -inf grows negative magnitudes
      RUP:     up = (r | s) & ~sign;    // toward +inf grows positive magnitudes
      RMM:     up = r;                  // ties away from zero
      ROD:     up = (r | s) & ~lsb;     // jam a 1 into the lsb when inexact
      default: up = 1'b0;
    endcase
    return up;
  endfunction

  // --------------------------------------------------------------------------
  // Rounding in front of stage 0
  // --------------------------------------------------------------------------
  logic                mode_err;
  rnd_mode_e           mode_eff;
  stage_t              round_res;
  logic [AbsWidth-1:0] lane_abs;
  logic [AbsWidth:0]   lane_sum;
  logic                lane_r;
  logic                lane_s;
  logic                lane_up;
  logic                lane_zero;

  // Per-lane round-up decision, increment, flags and lane masking.
  always_comb begin
    // NOTE: every variable written here gets a value before any branch, so
    // no path can leave one unassigned and turn it into a latch.
    mode_err  = (rnd_mode_i == 3'd6) || (rnd_mode_i == 3'd7);
    mode_eff  = mode_err ? RTZ : rnd_mode_e'(rnd_mode_i);
    round_res = '0;
    lane_abs  = '0;
    lane_sum  = '0;
    lane_r    = 1'b0;
    lane_s    = 1'b0;
    lane_up   = 1'b0;
    lane_zero = 1'b0;

    round_res.mode_err = mode_err;

    for (int k = 0; k < NumLanes; k++) begin
      lane_abs  = abs_value_i[k*AbsWidth +: AbsWidth];
      lane_r    = round_sticky_bits_i[2*k+1];
      lane_s    = round_sticky_bits_i[2*k];
      lane_up   = round_up_decision(mode_eff, lane_abs[0], sign_i[k], lane_r, lane_s);
      // One extra bit keeps the carry out of the wrapping increment.
      lane_sum  = {1'b0, lane_abs} + {{AbsWidth{1'b0}}, lane_up};
      lane_zero = (lane_abs == '0) && !lane_r && !lane_s;

      // Disabled lanes stay all-zero, including their sign and flags.
      if (lane_mask_i[k]) begin
        round_res.abs[k*AbsWidth +: AbsWidth] = lane_sum[AbsWidth-1:0];
        round_res.carry[k]      = lane_sum[AbsWidth];
        round_res.exact_zero[k] = lane_zero;
        round_res.inexact[k]    = lane_r | lane_s;
        // An exact zero produced by effective subtraction takes its sign
        // from the rounding direction: -0 only when rounding down.
        round_res.sign[k]       = (lane_zero && effective_subtraction_i[k])
                                  ? (mode_eff == RDN) : sign_i[k];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pipeline with per-stage valid/ready
  // --------------------------------------------------------------------------
  stage_t                 stage_q [NumPipeRegs];
  stage_t                 stage_d [NumPipeRegs];
  logic [NumPipeRegs-1:0] valid_q;
  logic [NumPipeRegs-1:0] valid_d;
  logic [NumPipeRegs-1:0] stage_ready;
  logic                   in_accept;

  // A stage can take new data unless it and every stage after it is full
  // while the consumer stalls; this is the unrolled form of
  // ready[i] = ~valid_q[i] | ready[i+1] with ready[last+1] = out_ready_i.
  for (genvar i = 0; i < NumPipeRegs; i++) begin : g_ready
    assign stage_ready[i] = out_ready_i | ~(&valid_q[NumPipeRegs-1:i]);
  end

  // The flush cycle refuses input so nothing enters a pipeline being emptied.
  assign in_ready_o = stage_ready[0] & ~flush_i;
  assign in_accept  = in_valid_i & in_ready_o;

  // Next-state of the stage registers: advance where ready, hold otherwise.
  always_comb begin
    for (int i = 0; i < NumPipeRegs; i++) begin
      valid_d[i] = valid_q[i];
      stage_d[i] = stage_q[i];
    end

    if (stage_ready[0]) begin
      valid_d[0] = in_accept;
    end
    if (in_accept) begin
      stage_d[0] = round_res;
    end

    for (int i = 1; i < NumPipeRegs; i++) begin
      if (stage_ready[i]) begin
        valid_d[i] = valid_q[i-1];
        if (valid_q[i-1]) begin
          stage_d[i] = stage_q[i-1];
        end
      end
    end

    if (flush_i) begin
      valid_d = '0;
    end
  end

  // Stage registers with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: state is updated with non-blocking assignments so every stage
    // samples its predecessor's old value, exactly like a chain of flops.
    if (!rst_ni) begin
      valid_q <= '0;
      // NOTE: the data registers are reset too, not only the valid bits,
      // because the outputs are required to read 0 while in reset.
      for (int i = 0; i < NumPipeRegs; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < NumPipeRegs; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign out_valid_o   = valid_q[NumPipeRegs-1];
  assign abs_rounded_o = stage_q[NumPipeRegs-1].abs;
  assign sign_o        = stage_q[NumPipeRegs-1].sign;
  assign exact_zero_o  = stage_q[NumPipeRegs-1].exact_zero;
  assign inexact_o     = stage_q[NumPipeRegs-1].inexact;
  assign carry_o       = stage_q[NumPipeRegs-1].carry;
  assign mode_err_o    = stage_q[NumPipeRegs-1].mode_err;

  // --------------------------------------------------------------------------
  // Sticky inexact status
  // --------------------------------------------------------------------------
`ifdef FPNEW_ROUNDING_STATUS_EN
  logic [NumLanes-1:0] status_q;
  logic [NumLanes-1:0] status_d;
  logic [NumLanes-1:0] hs_inexact;

  // Accumulate inexact lanes of every delivered result; a clear in the same
  // cycle as a delivery keeps only that delivery's flags.
  always_comb begin
    hs_inexact = (out_valid_o && out_ready_i) ? inexact_o : '0;
    status_d   = status_clr_i ? hs_inexact : (status_q | hs_inexact);
  end

  // Status register with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      status_q <= '0;
    end else begin
      status_q <= status_d;
    end
  end

  assign status_o = status_q;
`else
  // Without the accumulator the clear input has no function.
  logic unused_status_clr;
  assign unused_status_clr = status_clr_i;
  assign status_o          = '0;
`endif

endmodule

// File: tb/tb_fpnew_rounding_lanes.sv
// tb_fpnew_rounding_lanes
// Directed and randomized bench for fpnew_rounding_lanes (8-bit, 4 lanes,
// 2 stages). Expected results come from an arithmetic rounding model and an
// in-order queue of accepted transactions.
module tb_fpnew_rounding_lanes;

  localparam int W  = 8;
  localparam int NL = 4;
  localparam int NP = 2;

  typedef struct packed {
    logic [NL*W-1:0] abs;
    logic [NL-1:0]   sign;
    logic [NL-1:0]   esub;
    logic [NL-1:0]   mask;
    logic [2*NL-1:0] rs;
    logic [2:0]      mode;
  } req_t;

  typedef struct packed {
    logic [NL*W-1:0] abs;
    logic [NL-1:0]   sign;
    logic [NL-1:0]   ez;
    logic [NL-1:0]   inx;
    logic [NL-1:0]   carry;
    logic            merr;
  } res_t;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic            flush_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [NL*W-1:0] abs_value_i;
  logic [NL-1:0]   sign_i;
  logic [NL-1:0]   effective_subtraction_i;
  logic [NL-1:0]   lane_mask_i;
  logic [2*NL-1:0] round_sticky_bits_i;
  logic [2:0]      rnd_mode_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [NL*W-1:0] abs_rounded_o;
  logic [NL-1:0]   sign_o;
  logic [NL-1:0]   exact_zero_o;
  logic [NL-1:0]   inexact_o;
  logic [NL-1:0]   carry_o;
  logic            mode_err_o;
  logic [NL-1:0]   status_o;
  logic            status_clr_i;

  fpnew_rounding_lanes #(
    .AbsWidth   (W),
    .NumLanes   (NL),
    .NumPipeRegs(NP)
  ) dut (
    .clk_i                  (clk),
    .rst_ni                 (rst_ni),
    .flush_i                (flush_i),
    .in_valid_i             (in_valid_i),
    .in_ready_o             (in_ready_o),
    .abs_value_i            (abs_value_i),
    .sign_i                 (sign_i),
    .effective_subtraction_i(effective_subtraction_i),
    .lane_mask_i            (lane_mask_i),
    .round_sticky_bits_i    (round_sticky_bits_i),
    .rnd_mode_i             (rnd_mode_i),
    .out_valid_o            (out_valid_o),
    .out_ready_i            (out_ready_i),
    .abs_rounded_o          (abs_rounded_o),
    .sign_o                 (sign_o),
    .exact_zero_o           (exact_zero_o),
    .inexact_o              (inexact_o),
    .carry_o                (carry_o),
    .mode_err_o             (mode_err_o),
    .status_o               (status_o),
    .status_clr_i           (status_clr_i)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  res_t          exp_q[$];
  req_t          cur_req;
  logic [NL-1:0] st_exp = '0;

  // Per-cycle samples taken by tick()
  logic          t_acc = 1'b0;
  logic          t_ohs = 1'b0;
  logic          t_empty = 1'b0;
  logic          t_ovalid = 1'b0;
  logic          t_inrdy = 1'b0;
  res_t          t_obs;
  res_t          t_want;
  logic [NL-1:0] t_status;
  logic [NL-1:0] t_st_before;
  int            t_lat;

  // Reference rounding: fraction R,S read as quarters below the lsb.
  function automatic res_t model(input req_t q);
    res_t        r;
    int unsigned a, frac, up, sum, lim;
    r      = '0;
    lim    = 1 << W;
    r.merr = (q.mode >= 3'd6);
    for (int k = 0; k < NL; k++) begin
      if (!q.mask[k]) continue;
      a    = int'(q.abs[k*W +: W]);
      frac = int'(q.rs[2*k +: 2]);
      case (q.mode)
        3'd0:    up = ((frac == 3) || (frac == 2 && (a % 2) == 1)) ? 1 : 0;
        3'd2:    up = (frac != 0 && q.sign[k]) ? 1 : 0;
        3'd3:    up = (frac != 0 && !q.sign[k]) ? 1 : 0;
        3'd4:    up = (frac >= 2) ? 1 : 0;
        3'd5:    up = (frac != 0 && (a % 2) == 0) ? 1 : 0;
        default: up = 0;
      endcase
      sum               = a + up;
      r.abs[k*W +: W]   = W'(sum % lim);
      r.carry[k]        = (sum >= lim);
      r.inx[k]          = (frac != 0);
      r.ez[k]           = (a == 0 && frac == 0);
      r.sign[k]         = (r.ez[k] && q.esub[k]) ? (q.mode == 3'd2) : q.sign[k];
    end
    return r;
  endfunction

  function automatic res_t observe();
    res_t o;
    o.abs   = abs_rounded_o;
    o.sign  = sign_o;
    o.ez    = exact_zero_o;
    o.inx   = inexact_o;
    o.carry = carry_o;
    o.merr  = mode_err_o;
    return o;
  endfunction

  function automatic req_t rand_req();
    req_t q;
    for (int k = 0; k < NL; k++) begin
      case ($urandom_range(0, 7))
        0:       q.abs[k*W +: W] = '0;
        1:       q.abs[k*W +: W] = '1;
        default: q.abs[k*W +: W] = W'($urandom);
      endcase
    end
    q.sign = NL'($urandom);
    q.esub = NL'($urandom);
    q.mask = NL'($urandom) | NL'($urandom);
    q.rs   = (2*NL)'($urandom);
    q.mode = 3'($urandom_range(0, 7));
    return q;
  endfunction

  task automatic set_req(input req_t q, input logic v);
    cur_req                 = q;
    abs_value_i             = q.abs;
    sign_i                  = q.sign;
    effective_subtraction_i = q.esub;
    lane_mask_i             = q.mask;
    round_sticky_bits_i     = q.rs;
    rnd_mode_i              = q.mode;
    in_valid_i              = v;
  endtask

  // One clock: sample at the falling edge, update queue and status model,
  // then return just after the rising edge for the next stimulus.
  task automatic tick();
    logic [NL-1:0] h;
    @(negedge clk);
    t_acc       = in_valid_i && in_ready_o;
    t_ohs       = out_valid_o && out_ready_i;
    t_ovalid    = out_valid_o;
    t_inrdy     = in_ready_o;
    t_obs       = observe();
    t_status    = status_o;
    t_st_before = st_exp;
    t_empty     = 1'b0;
    t_want      = '0;
    if (t_ohs) begin
      if (exp_q.size() == 0) t_empty = 1'b1;
      else                   t_want  = exp_q.pop_front();
    end
    if (t_acc) exp_q.push_back(model(cur_req));
    h = t_ohs ? t_want.inx : '0;
`ifdef FPNEW_ROUNDING_STATUS_EN
    st_exp = status_clr_i ? h : (st_exp | h);
`else
    st_exp = '0;
`endif
    @(posedge clk);
    #1;
  endtask

  // Offer one transaction and wait for its result, bounded both ways.
  task automatic send_one(input req_t q);
    int n;
    out_ready_i = 1'b1;
    set_req(q, 1'b1);
    n = 0;
    t_acc = 1'b0;
    while (!t_acc && n < 20) begin tick(); n++; end
    in_valid_i = 1'b0;
    if (!t_acc) begin
      n_cmp++; n_err++;
      $display("FAIL send_accept_timeout: got no accept want accept within 20 cycles");
    end
    n = 0;
    t_ohs = 1'b0;
    while (!t_ohs && n < 20) begin tick(); n++; end
    t_lat = n;
    if (!t_ohs) begin
      n_cmp++; n_err++;
      $display("FAIL send_result_timeout: got no output want output within 20 cycles");
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; flush_i = 1'b0; out_ready_i = 1'b0; status_clr_i = 1'b0;
    set_req('0, 1'b0);
    #1;
    n_cmp++;
    if (observe() !== '0 || out_valid_o !== 1'b0 || status_o !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got res=%h v=%b st=%h want all 0", observe(), out_valid_o, status_o);
    end
    @(negedge clk); @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b want 1 0", in_ready_o, out_valid_o);
    end
  endtask

  task automatic test_rne_latency();
    req_t q;
    q.abs = {8'h03, 8'h07, 8'h04, 8'h05};
    q.rs  = {2'b01, 2'b11, 2'b10, 2'b10};
    q.sign = '0; q.esub = '0; q.mask = '1; q.mode = 3'd0;
    send_one(q);
    n_cmp++;
    if (t_lat !== NP) begin
      n_err++; $display("FAIL rne_latency: got %0d want %0d cycles", t_lat, NP);
    end
    n_cmp++;
    if (t_obs.abs !== 32'h03080406 || t_obs.inx !== 4'hF) begin
      n_err++; $display("FAIL rne_vector: got abs=%h inx=%b want 03080406 1111", t_obs.abs, t_obs.inx);
    end
    n_cmp++;
    if (t_empty || t_obs !== t_want) begin
      n_err++; $display("FAIL rne_model: got %h want %h", t_obs, t_want);
    end
  endtask

  task automatic test_wrap_sign();
    req_t q;
    q.abs = '1; q.rs = '1; q.sign = '0; q.esub = '0; q.mask = '1; q.mode = 3'd0;
    send_one(q);
    n_cmp++;
    if (t_obs.abs !== '0 || t_obs.carry !== 4'hF || t_obs.ez !== 4'h0) begin
      n_err++; $display("FAIL wrap: got abs=%h carry=%b ez=%b want 0 1111 0000", t_obs.abs, t_obs.carry, t_obs.ez);
    end
    q.abs = '0; q.rs = '0; q.esub = '1; q.sign = '0; q.mode = 3'd2;
    send_one(q);
    n_cmp++;
    if (t_obs.sign !== 4'hF || t_obs.ez !== 4'hF) begin
      n_err++; $display("FAIL zero_sign_rdn: got sign=%b ez=%b want 1111 1111", t_obs.sign, t_obs.ez);
    end
    q.sign = '1; q.mode = 3'd0;
    send_one(q);
    n_cmp++;
    if (t_obs.sign !== 4'h0 || t_obs.ez !== 4'hF) begin
      n_err++; $display("FAIL zero_sign_rne: got sign=%b ez=%b want 0000 1111", t_obs.sign, t_obs.ez);
    end
  endtask

  task automatic test_rod_invalid();
    req_t q;
    q.abs = {8'h06, 8'h06, 8'h05, 8'h04};
    q.rs  = {2'b00, 2'b00, 2'b01, 2'b01};
    q.sign = '0; q.esub = '0; q.mask = '1; q.mode = 3'd5;
    send_one(q);
    n_cmp++;
    if (t_obs.abs !== 32'h06060505 || t_obs.merr !== 1'b0) begin
      n_err++; $display("FAIL rod: got abs=%h merr=%b want 06060505 0", t_obs.abs, t_obs.merr);
    end
    q.abs = {4{8'h05}}; q.rs = '1; q.mode = 3'd6;
    send_one(q);
    n_cmp++;
    if (t_obs.abs !== 32'h05050505 || t_obs.merr !== 1'b1 || t_obs.carry !== 4'h0) begin
      n_err++; $display("FAIL mode6: got abs=%h merr=%b want 05050505 1", t_obs.abs, t_obs.merr);
    end
  endtask

  task automatic test_mask_status();
    req_t          q;
    logic [NL-1:0] want_st;
    status_clr_i = 1'b1; tick();
    status_clr_i = 1'b0; tick();
    n_cmp++;
    if (t_status !== '0) begin
      n_err++; $display("FAIL status_clear_pre: got %b want 0000", t_status);
    end
    q.abs = {4{8'h5A}}; q.rs = '1; q.sign = '1; q.esub = '1; q.mask = 4'b0101; q.mode = 3'd3;
    send_one(q);
    n_cmp++;
    if (t_obs.abs[15:8] !== 8'h00 || t_obs.abs[31:24] !== 8'h00 ||
        ((t_obs.sign | t_obs.ez | t_obs.inx | t_obs.carry) & 4'b1010) !== 4'b0000 ||
        t_obs.abs[7:0] !== 8'h5A || t_obs.inx !== 4'b0101) begin
      n_err++; $display("FAIL lane_mask: got %h want lanes 1,3 zero, lanes 0,2 5A inexact", t_obs);
    end
    tick();
`ifdef FPNEW_ROUNDING_STATUS_EN
    want_st = 4'b0101;
`else
    want_st = 4'b0000;
`endif
    n_cmp++;
    if (t_status !== want_st) begin
      n_err++; $display("FAIL status_accumulate: got %b want %b", t_status, want_st);
    end
    status_clr_i = 1'b1; tick();
    status_clr_i = 1'b0; tick();
    n_cmp++;
    if (t_status !== '0) begin
      n_err++; $display("FAIL status_clear: got %b want 0000", t_status);
    end
  endtask

  task automatic test_backpressure();
    req_t r [4];
    int   idx, got, n;
    for (int i = 0; i < 4; i++) r[i] = rand_req();
    out_ready_i = 1'b0;
    idx = 0;
    for (int c = 0; c < 3; c++) begin
      set_req(r[idx], 1'b1);
      tick();
      if (t_acc) idx++;
    end
    n_cmp++;
    if (idx !== 2 || in_ready_o !== 1'b0) begin
      n_err++; $display("FAIL bp_fill: got accepts=%0d in_ready=%b want 2 0", idx, in_ready_o);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (!t_ovalid || t_acc || t_obs !== model(r[0])) begin
        n_err++; $display("FAIL bp_hold: got v=%b acc=%b %h want 1 0 %h", t_ovalid, t_acc, t_obs, model(r[0]));
      end
    end
    out_ready_i = 1'b1;
    got = 0; n = 0;
    while ((idx < 4 || exp_q.size() > 0) && n < 30) begin
      if (idx < 4) set_req(r[idx], 1'b1);
      else         in_valid_i = 1'b0;
      tick();
      n++;
      if (t_acc) idx++;
      if (t_ohs) begin
        got++;
        n_cmp++;
        if (t_empty || t_obs !== t_want) begin
          n_err++; $display("FAIL bp_order: got %h want %h", t_obs, t_want);
        end
      end
    end
    in_valid_i = 1'b0;
    n_cmp++;
    if (got !== 4) begin
      n_err++; $display("FAIL bp_count: got %0d results want 4", got);
    end
  endtask

  task automatic test_flush();
    int idx, n, stale;
    out_ready_i = 1'b0;
    idx = 0; n = 0;
    while (idx < 2 && n < 10) begin
      set_req(rand_req(), 1'b1);
      tick(); n++;
      if (t_acc) idx++;
    end
    set_req(rand_req(), 1'b1);
    flush_i = 1'b1;
    tick();
    n_cmp++;
    if (t_inrdy !== 1'b0 || t_acc !== 1'b0 || idx !== 2) begin
      n_err++; $display("FAIL flush_ready: got in_ready=%b accepted_before=%0d want 0 2", t_inrdy, idx);
    end
    flush_i = 1'b0; in_valid_i = 1'b0;
    exp_q.delete();
    tick();
    n_cmp++;
    if (t_ovalid !== 1'b0) begin
      n_err++; $display("FAIL flush_valid: got out_valid=%b want 0", t_ovalid);
    end
    out_ready_i = 1'b1;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (t_ovalid) stale++;
    end
    n_cmp++;
    if (stale !== 0) begin
      n_err++; $display("FAIL flush_stale: got %0d outputs want 0", stale);
    end
  endtask

  task automatic test_random();
    int n;
    in_valid_i = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!in_valid_i || t_acc) set_req(rand_req(), ($urandom_range(0, 3) != 0));
      out_ready_i  = ($urandom_range(0, 9) < 7);
      status_clr_i = ($urandom_range(0, 9) == 0);
      tick();
      if (t_ohs) begin
        n_cmp++;
        if (t_empty || t_obs !== t_want) begin
          n_err++; $display("FAIL rand_result: got %h want %h", t_obs, t_want);
        end
      end
      n_cmp++;
      if (t_status !== t_st_before) begin
        n_err++; $display("FAIL rand_status: got %b want %b", t_status, t_st_before);
      end
    end
    in_valid_i = 1'b0; out_ready_i = 1'b1; status_clr_i = 1'b0;
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      tick(); n++;
      if (t_ohs) begin
        n_cmp++;
        if (t_empty || t_obs !== t_want) begin
          n_err++; $display("FAIL rand_drain: got %h want %h", t_obs, t_want);
        end
      end
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_err++; $display("FAIL rand_lost: got %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    req_t q;
    int   n;
    q = rand_req();
    q.mode = 3'd7; q.mask = '1; q.abs = {4{8'h33}}; q.rs = '1;
    out_ready_i = 1'b0;
    set_req(q, 1'b1);
    n = 0;
    while (exp_q.size() < 2 && n < 10) begin tick(); n++; end
    tick();
    n_cmp++;
    if (t_ovalid !== 1'b1 || t_obs.merr !== 1'b1) begin
      n_err++; $display("FAIL areset_pre: got v=%b merr=%b want 1 1", t_ovalid, t_obs.merr);
    end
    rst_ni = 1'b0;
    #2;
    n_cmp++;
    if (out_valid_o !== 1'b0 || observe() !== '0 || status_o !== '0 || mode_err_o !== 1'b0) begin
      n_err++; $display("FAIL areset_async: got v=%b res=%h st=%b want all 0", out_valid_o, observe(), status_o);
    end
    exp_q.delete(); st_exp = '0; in_valid_i = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
      n_err++; $display("FAIL areset_release: got in_ready=%b out_valid=%b want 1 0", in_ready_o, out_valid_o);
    end
    out_ready_i = 1'b1;
    n = 0;
    for (int c = 0; c < 4; c++) begin tick(); if (t_ovalid) n++; end
    n_cmp++;
    if (n !== 0) begin
      n_err++; $display("FAIL areset_stale: got %0d outputs want 0", n);
    end
  endtask

  initial begin
    test_reset();
    test_rne_latency();
    test_wrap_sign();
    test_rod_invalid();
    test_mask_status();
    test_backpressure();
    test_flush();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
